// File: rtl/param_wt_cache.sv
// Direct-mapped, write-through, write-allocate cache with a valid/ready CPU side,
// a line-wide memory side that yields to DMA (BG), flush, and saturating hit/miss counters.
module param_wt_cache #(
  parameter int unsigned WORD_SIZE      = 16,
  parameter int unsigned NUM_LINES      = 4,
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned LATENCY        = 4,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                read_cache,
  input  logic                                write_cache,
  input  logic [WORD_SIZE-1:0]                address_cache,
  input  logic [WORD_SIZE-1:0]                wdata_cache,
  output logic [WORD_SIZE-1:0]                rdata_cache,
  output logic                                ready_cache,
  input  logic                                flush,
  input  logic                                BG,
  output logic [WORD_SIZE-1:0]                address_memory,
  output logic                                readM,
  output logic                                writeM,
  input  logic [WORD_SIZE*WORDS_PER_LINE-1:0] data_mem_in,
  output logic [WORD_SIZE*WORDS_PER_LINE-1:0] data_mem_out,
  output logic [CNT_W-1:0]                    num_cache_hit,
  output logic [CNT_W-1:0]                    num_cache_miss
);

  localparam int unsigned OFF_W  = $clog2(WORDS_PER_LINE);
  localparam int unsigned IDX_W  = $clog2(NUM_LINES);
  localparam int unsigned TAG_W  = WORD_SIZE - OFF_W - IDX_W;
  localparam int unsigned LINE_W = WORD_SIZE * WORDS_PER_LINE;
  localparam int unsigned LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAST_CNT = LAT_W'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  state_t               state_q, state_d;
  logic [LAT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]     tag_bank_q [NUM_LINES];
  logic [LINE_W-1:0]    line_bank_q [NUM_LINES];
  logic                 req_wr_q, req_wr_d;
  logic [OFF_W-1:0]     req_off_q, req_off_d;
  logic [IDX_W-1:0]     req_idx_q, req_idx_d;
  logic [TAG_W-1:0]     req_tag_q, req_tag_d;
  logic [WORD_SIZE-1:0] req_wdata_q, req_wdata_d;
  logic [WORD_SIZE-1:0] rdata_q, rdata_d;
  logic [WORD_SIZE-1:0] addr_mem_q, addr_mem_d;
  logic [LINE_W-1:0]    dmo_q, dmo_d;
  logic [CNT_W-1:0]     hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]     miss_cnt_q, miss_cnt_d;

  logic                 bank_we_c;
  logic [IDX_W-1:0]     bank_idx_c;
  logic [TAG_W-1:0]     bank_tag_c;
  logic [LINE_W-1:0]    bank_line_c;
  logic [LINE_W-1:0]    fill_line_c;
  logic [OFF_W-1:0]     in_off_c;
  logic [IDX_W-1:0]     in_idx_c;
  logic [TAG_W-1:0]     in_tag_c;
  logic                 in_hit_c;

  assign in_off_c = address_cache[OFF_W-1:0];
  assign in_idx_c = address_cache[OFF_W +: IDX_W];
  assign in_tag_c = address_cache[WORD_SIZE-1 -: TAG_W];
  assign in_hit_c = valid_q[in_idx_c] && (tag_bank_q[in_idx_c] == in_tag_c);

  // Word offset 0 sits in the line MSBs.
  function automatic logic [WORD_SIZE-1:0] get_word(input logic [LINE_W-1:0] line,
                                                    input logic [OFF_W-1:0]  off);
    return line[(WORDS_PER_LINE - 1 - 32'(off)) * WORD_SIZE +: WORD_SIZE];
  endfunction

  function automatic logic [LINE_W-1:0] put_word(input logic [LINE_W-1:0]    line,
                                                 input logic [OFF_W-1:0]     off,
                                                 input logic [WORD_SIZE-1:0] w);
    logic [LINE_W-1:0] m;
    m = line;
    m[(WORDS_PER_LINE - 1 - 32'(off)) * WORD_SIZE +: WORD_SIZE] = w;
    return m;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    valid_d     = valid_q;
    req_wr_d    = req_wr_q;
    req_off_d   = req_off_q;
    req_idx_d   = req_idx_q;
    req_tag_d   = req_tag_q;
    req_wdata_d = req_wdata_q;
    rdata_d     = rdata_q;
    addr_mem_d  = addr_mem_q;
    dmo_d       = dmo_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    bank_we_c   = 1'b0;
    bank_idx_c  = req_idx_q;
    bank_tag_c  = req_tag_q;
    bank_line_c = '0;
    fill_line_c = req_wr_q ? put_word(data_mem_in, req_off_q, req_wdata_q) : data_mem_in;

    case (state_q)
      IDLE: begin
        if (flush) begin
          valid_d = '0;
        end else if (read_cache || write_cache) begin
          req_wr_d    = write_cache;
          req_off_d   = in_off_c;
          req_idx_d   = in_idx_c;
          req_tag_d   = in_tag_c;
          req_wdata_d = wdata_cache;
          addr_mem_d  = {address_cache[WORD_SIZE-1:OFF_W], OFF_W'(0)};
          cnt_d       = '0;
          if (in_hit_c) begin
            hit_cnt_d = sat_inc(hit_cnt_q);
            if (write_cache) begin
              bank_we_c   = 1'b1;
              bank_idx_c  = in_idx_c;
              bank_tag_c  = in_tag_c;
              bank_line_c = put_word(line_bank_q[in_idx_c], in_off_c, wdata_cache);
              dmo_d       = bank_line_c;
              state_d     = WRITE;
            end else begin
              rdata_d = get_word(line_bank_q[in_idx_c], in_off_c);
              state_d = DONE;
            end
          end else begin
            miss_cnt_d = sat_inc(miss_cnt_q);
            state_d    = FILL;
          end
        end
      end
      // A grant to DMA restarts the line transfer from scratch.
      FILL: begin
        if (BG) begin
          cnt_d = '0;
        end else if (cnt_q == LAST_CNT) begin
          bank_we_c          = 1'b1;
          bank_line_c        = fill_line_c;
          valid_d[req_idx_q] = 1'b1;
          cnt_d              = '0;
          if (req_wr_q) begin
            dmo_d   = fill_line_c;
            state_d = WRITE;
          end else begin
            rdata_d = get_word(data_mem_in, req_off_q);
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q + LAT_W'(1);
        end
      end
      WRITE: begin
        if (BG) begin
          cnt_d = '0;
        end else if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + LAT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      valid_q     <= '0;
      req_wr_q    <= 1'b0;
      req_off_q   <= '0;
      req_idx_q   <= '0;
      req_tag_q   <= '0;
      req_wdata_q <= '0;
      rdata_q     <= '0;
      addr_mem_q  <= '0;
      dmo_q       <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      req_wr_q    <= req_wr_d;
      req_off_q   <= req_off_d;
      req_idx_q   <= req_idx_d;
      req_tag_q   <= req_tag_d;
      req_wdata_q <= req_wdata_d;
      rdata_q     <= rdata_d;
      addr_mem_q  <= addr_mem_d;
      dmo_q       <= dmo_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  // Tag/data arrays need no reset: the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (bank_we_c && !reset) begin
      tag_bank_q[bank_idx_c]  <= bank_tag_c;
      line_bank_q[bank_idx_c] <= bank_line_c;
    end
  end

  assign readM          = (state_q == FILL) && !BG;
  assign writeM         = (state_q == WRITE) && !BG;
  assign ready_cache    = (state_q == DONE);
  assign rdata_cache    = rdata_q;
  assign address_memory = addr_mem_q;
  assign data_mem_out   = dmo_q;
  assign num_cache_hit  = hit_cnt_q;
  assign num_cache_miss = miss_cnt_q;

endmodule
